// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multicycle controller.
package mc_pkg;
  localparam int MC_MEM_TIMEOUT = 15;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_e;
  typedef enum logic [3:0] {
    K_NOP, K_ALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JR, K_JAL, K_JALR
  } kind_e;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [4:0] ALU_NONE = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_SLT  = 5'd5;
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] PC_REG = 2'b11;
  localparam logic [1:0] WA_RD  = 2'b00;
  localparam logic [1:0] WA_RT  = 2'b01;
  localparam logic [1:0] WA_RA  = 2'b10;
  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_PC4 = 2'b01;
  localparam logic [1:0] WD_MEM = 2'b10;
  typedef struct packed {
    logic [1:0] wasel;
    logic [1:0] wdsel;
    logic [1:0] asel;
    logic       bsel;
    logic       sgnext;
    logic [4:0] alufn;
  } ctl_t;
  function automatic ctl_t mk_ctl(logic [1:0] wa, logic [1:0] wd, logic b, logic s, logic [4:0] fn);
    return '{wasel: wa, wdsel: wd, asel: 2'b00, bsel: b, sgnext: s, alufn: fn};
  endfunction
endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational op/func decode into datapath controls, instruction kind and legal flag.
module mc_decode import mc_pkg::*; (
  input  logic [5:0] op,
  input  logic [5:0] func,
  output ctl_t       ctl,
  output kind_e      kind,
  output logic       legal
);
  always_comb begin
    ctl = '0;
    kind = K_NOP;
    legal = 1'b1;
    case (op)
      OP_RTYPE:
        case (func)
          FN_ADD:  begin kind = K_ALU; ctl = mk_ctl(WA_RD, WD_ALU, 1'b0, 1'b0, ALU_ADD); end
          FN_SUB:  begin kind = K_ALU; ctl = mk_ctl(WA_RD, WD_ALU, 1'b0, 1'b0, ALU_SUB); end
          FN_AND:  begin kind = K_ALU; ctl = mk_ctl(WA_RD, WD_ALU, 1'b0, 1'b0, ALU_AND); end
          FN_OR:   begin kind = K_ALU; ctl = mk_ctl(WA_RD, WD_ALU, 1'b0, 1'b0, ALU_OR); end
          FN_SLT:  begin kind = K_ALU; ctl = mk_ctl(WA_RD, WD_ALU, 1'b0, 1'b0, ALU_SLT); end
          FN_JR:   kind = K_JR;
          FN_JALR: begin kind = K_JALR; ctl = mk_ctl(WA_RD, WD_PC4, 1'b0, 1'b0, ALU_NONE); end
          default: legal = 1'b0;
        endcase
      OP_ADDI: begin kind = K_ALU; ctl = mk_ctl(WA_RT, WD_ALU, 1'b1, 1'b1, ALU_ADD); end
      OP_LW:   begin kind = K_LW; ctl = mk_ctl(WA_RT, WD_MEM, 1'b1, 1'b1, ALU_ADD); end
      OP_SW:   begin kind = K_SW; ctl = mk_ctl(WA_RD, WD_ALU, 1'b1, 1'b1, ALU_ADD); end
      OP_BEQ:  begin kind = K_BEQ; ctl = mk_ctl(WA_RD, WD_ALU, 1'b0, 1'b1, ALU_SUB); end
      OP_BNE:  begin kind = K_BNE; ctl = mk_ctl(WA_RD, WD_ALU, 1'b0, 1'b1, ALU_SUB); end
      OP_J:    kind = K_J;
      OP_JAL:  begin kind = K_JAL; ctl = mk_ctl(WA_RA, WD_PC4, 1'b0, 1'b0, ALU_NONE); end
      default: legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle FSM with memory wait timeout and sticky error.
// Define MC_TRAP_EN to trap unknown instructions into ERR instead of running them as NOPs.
module mc_controller import mc_pkg::*; #(
  parameter int MEM_TIMEOUT = MC_MEM_TIMEOUT,
  parameter int ALUFN_W     = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [5:0]         op,
  input  logic [5:0]         func,
  input  logic               Z,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_wr,
  output logic               iord,
  output logic               ir_we,
  output logic               pc_we,
  output logic               werf,
  output logic [1:0]         pcsel,
  output logic [1:0]         wasel,
  output logic [1:0]         wdsel,
  output logic [1:0]         asel,
  output logic               bsel,
  output logic               sgnext,
  output logic [ALUFN_W-1:0] alufn,
  output logic [2:0]         state,
  output logic               err
);
  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);
  state_e     state_q, state_d;
  kind_e      kind_q, kind_d, dec_kind;
  ctl_t       ctl_q, ctl_d, dec_ctl, ctl_o;
  logic [7:0] wcnt_q, wcnt_d;
  logic       err_q, err_d, dec_legal, waiting;
  mc_decode u_dec (.op(op), .func(func), .ctl(dec_ctl), .kind(dec_kind), .legal(dec_legal));
  always_comb begin
    state_d = state_q;
    kind_d = kind_q;
    ctl_d = ctl_q;
    wcnt_d = wcnt_q;
    err_d = err_q;
    mem_req = 1'b0;
    mem_wr = 1'b0;
    ir_we = 1'b0;
    pc_we = 1'b0;
    werf = 1'b0;
    pcsel = PC_SEQ;
    waiting = 1'b0;
    if (enable) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we = mem_ack;
          state_d = mem_ack ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          kind_d = dec_legal ? dec_kind : K_NOP;
          ctl_d = dec_ctl;
          state_d = S_EXEC;
`ifdef MC_TRAP_EN
          if (!dec_legal) begin
            state_d = S_ERR;
            err_d = 1'b1;
          end
`endif
        end
        S_EXEC:
          case (kind_q)
            K_LW, K_SW: state_d = S_MEM;
            K_ALU, K_JAL, K_JALR: state_d = S_WB;
            default: begin
              pc_we = 1'b1;
              pcsel = (kind_q == K_BEQ) ? (Z ? PC_BR : PC_SEQ) :
                      (kind_q == K_BNE) ? (Z ? PC_SEQ : PC_BR) :
                      (kind_q == K_J)   ? PC_JMP :
                      (kind_q == K_JR)  ? PC_REG : PC_SEQ;
              state_d = S_FETCH;
            end
          endcase
        S_MEM: begin
          mem_req = 1'b1;
          mem_wr = (kind_q == K_SW);
          pc_we = mem_ack && (kind_q == K_SW);
          state_d = !mem_ack ? S_MEM : (kind_q == K_SW) ? S_FETCH : S_WB;
        end
        S_WB: begin
          werf = 1'b1;
          pc_we = 1'b1;
          pcsel = (kind_q == K_JAL) ? PC_JMP : (kind_q == K_JALR) ? PC_REG : PC_SEQ;
          state_d = S_FETCH;
        end
        S_ERR: ;
        default: begin
          state_d = S_ERR;
          err_d = 1'b1;
        end
      endcase
      // An ack ends the wait; any other state clears it because mem_req is low there.
      waiting = mem_req && !mem_ack;
      wcnt_d = waiting ? wcnt_q + 8'd1 : 8'd0;
      if (waiting && wcnt_d == TMO) begin
        state_d = S_ERR;
        err_d = 1'b1;
        wcnt_d = 8'd0;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_FETCH;
      kind_q <= K_NOP;
      ctl_q <= '0;
      wcnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q <= kind_d;
      ctl_q <= ctl_d;
      wcnt_q <= wcnt_d;
      err_q <= err_d;
    end
  // Selects follow the live decode in DECODE, then the latched copy until the instruction ends.
  assign ctl_o = (state_q == S_DECODE) ? dec_ctl :
                 (state_q == S_FETCH || state_q == S_ERR) ? ctl_t'('0) : ctl_q;
  assign iord = (state_q == S_MEM);
  assign wasel = ctl_o.wasel;
  assign wdsel = ctl_o.wdsel;
  assign asel = ctl_o.asel;
  assign bsel = ctl_o.bsel;
  assign sgnext = ctl_o.sgnext;
  assign alufn = ALUFN_W'(ctl_o.alufn);
  assign state = state_q;
  assign err = err_q;
endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL run on one clock; reset is asynchronous and active-low.
REQ-002 SHALL take parameter MEM_TIMEOUT, default 15: maximum wait cycles for mem_ack, range 1..255.
REQ-003 SHALL take parameter ALUFN_W, default 5: width of alufn.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  rising-edge clock
- reset_n  in  1  async active-low reset
- enable  in  1  processor run; 0 freezes the controller
- op  in  6  opcode field
- func  in  6  R-type function field
- Z  in  1  ALU zero flag
- mem_ack  in  1  memory completes the current request
- mem_req  out  1  memory request
- mem_wr  out  1  store request
- iord  out  1  address select: 0 = PC, 1 = ALU result
- ir_we  out  1  instruction register load
- pc_we  out  1  PC load
- werf  out  1  register file write
- pcsel  out  2  00 = PC+4, 01 = branch, 10 = jump, 11 = register
- wasel  out  2  write-address select
- wdsel  out  2  write-data select
- asel  out  2  A-operand select
- bsel  out  1  B-operand select
- sgnext  out  1  sign-extend immediate
- alufn  out  ALUFN_W  ALU function
- state  out  3  current FSM state
- err  out  1  sticky error flag

Function
REQ-005 SHALL use the FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=5.
REQ-006 FETCH: SHALL assert mem_req=1 and iord=0; on mem_ack=1, SHALL assert ir_we=1 in that same cycle and go to DECODE.
REQ-007 DECODE: SHALL spend one cycle, then go to EXEC.
REQ-008 EXEC, LW/SW: SHALL go to MEM.
REQ-009 EXEC, BEQ/BNE/J/JR: SHALL assert pc_we=1 with the final pcsel and go to FETCH. Branch pcsel is 01 only when the Z condition holds, else 00.
REQ-010 EXEC, ALU ops, JAL and JALR: SHALL go to WB.
REQ-011 MEM: SHALL assert mem_req=1 and iord=1, plus mem_wr=1 for SW. On mem_ack, SW SHALL assert pc_we=1 and go to FETCH; LW SHALL go to WB.
REQ-012 WB: SHALL assert werf=1 and pc_we=1, then go to FETCH.
REQ-013 Latency with mem_ack in the same cycle as the request SHALL be:
- R-type: 4 cycles
- LW: 5 cycles
- SW: 4 cycles
- branch/jump: 3 cycles
REQ-014 SHALL hold wasel, wdsel, asel, bsel, sgnext and alufn stable, decoded from op/func, in DECODE through the instruction's final state.
REQ-015 Wait counter: SHALL count consecutive cycles in FETCH or MEM with mem_req=1 and mem_ack=0. It clears on ack or state change.
REQ-016 When the wait counter reaches MEM_TIMEOUT, SHALL go to ERR and set err=1.
REQ-017 ERR: SHALL force every strobe (mem_req, mem_wr, ir_we, pc_we, werf) to 0, and leave ERR only on reset.
REQ-018 enable=0: SHALL hold state and wait counter, and force mem_req, mem_wr, ir_we, pc_we and werf to 0.
REQ-019 mem_ack arriving while enable=0 SHALL be ignored.
REQ-020 mem_ack outside FETCH/MEM SHALL be ignored.

Reset
REQ-021 While reset_n=0, SHALL set state=FETCH, wait counter=0 and err=0, with every strobe output at 0 and the select outputs at 0.
REQ-022 Reset assertion mid-instruction SHALL abort the instruction with no pc_we, werf or mem_wr pulse; the first request after release is a fetch.

Configuration
REQ-023 With MC_TRAP_EN defined, an unknown op or func in DECODE SHALL go to ERR and set err=1.
REQ-024 Without MC_TRAP_EN, an unknown instruction SHALL execute as a NOP: EXEC asserts pc_we=1 with pcsel=00 and werf=0.

Structure
REQ-025 Package mc_pkg SHALL hold:
- the state enum
- opcode and func constants
- alufn encodings
- the packed datapath-control struct
- the MEM_TIMEOUT default
REQ-026 Combinational decode SHALL live in sub-module mc_decode (op, func → control struct plus a legal flag); mc_controller holds the FSM, wait counter and err.

Verification
REQ-027 The bench SHALL cover:
- ADD (op=000000, func=100000), ack same cycle → states 0,1,2,4 then 0; werf=1 only in WB; alufn=00001; pc_we=1 once.
- LW (op=100011), data ack after 3 wait cycles → MEM lasts 4 cycles; iord=1, mem_wr=0; werf=1 in WB; wdsel=10, bsel=1, sgnext=1.
- BEQ with Z=1, then Z=0 → pc_we=1 in EXEC with pcsel=01, then 00; no WB visit; werf never set.
- FETCH with no ack, MEM_TIMEOUT=4 → ERR after 4 wait cycles; err=1 and all strobes 0 until reset_n pulse, then FETCH.
- enable=0 for 3 cycles mid-MEM on SW, with mem_ack pulsed during the freeze → state holds; mem_req=0 and mem_wr=0; the ack is ignored; the instruction completes after re-enable.
- op=111111 → err=1 and ERR with MC_TRAP_EN; without it, returns to FETCH with pc_we=1, pcsel=00 and no werf.
